mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers for the MIPS core.
- Sits beside the ALU in data_path and is driven by cntrl.
- Executes MULT/MULTU/DIV/DIVU in WIDTH cycles using radix-2 shift-add and restoring division.
- Also supports MTHI/MTLO writes, abort (flush), and a div-by-zero flag.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (even, >=4)
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled with op/a/b when unit is not RUN
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  WIDTH  rs operand (multiplicand / dividend)
b  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  abort in-flight operation
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  high while state==RUN
done  out  1  one-cycle completion pulse (state==DONE)
div_by_zero  out  1  sticky per op; set when a DIV/DIVU completes with b==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (sync, clk edge with rst=1):
  - State IDLE; hi=lo=0; busy=done=div_by_zero=0; counter=0.
  - rst overrides all other inputs, including a mid-operation RUN.
- States IDLE, RUN, DONE.
  - IDLE/DONE --start--> RUN: latch |a|, |b| (signed ops take magnitude), result-sign bits, op; counter=0; clear div_by_zero.
  - RUN: one iteration per edge; counter++.
    - When counter==WIDTH-1 at the edge, apply sign fix-up, write hi/lo, and go to DONE.
    - done is therefore high exactly WIDTH edges after the accepting edge, for one cycle.
  - DONE --no start--> IDLE. A start during DONE is accepted (back-to-back, no bubble).
- start while busy is ignored (not queued); op/a/b changes during RUN have no effect.
- flush during RUN: next state IDLE, hi/lo unchanged, no done pulse. flush in IDLE/DONE has no effect. If flush and start are both high while RUN, flush wins and start is dropped.
- Multiply: 2*WIDTH-bit product; hi=upper half, lo=lower half. Signed result is two's-complement negated when the operand signs differ.
- Divide:
  - lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - b==0: hi=a, lo=all ones, div_by_zero=1. Latency is unchanged (still WIDTH edges).
  - Signed most-negative / -1: lo=most-negative, hi=0 (wrap, no trap).
  - Signed magnitude of the most-negative value is handled as an unsigned WIDTH-bit value (no extra bit lost).
- MTHI/MTLO:
  - hi_we/lo_we take effect at the edge in IDLE or DONE.
  - Ignored in RUN.
  - In DONE they overwrite the just-produced result (the later write wins).
- Outputs are registered; hi/lo change only on a RUN->DONE edge, an MTHI/MTLO write, or reset.

Decomposition:
- Shared package mips_pkg:
  - MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - State encodings MD_IDLE/MD_RUN/MD_DONE.
- Sub-module mips_muldiv_step: purely combinational single iteration. Inputs are mode (mul/div), partial accumulator, and shift register; outputs are the next accumulator and shift register.
- The top level holds the FSM, counter, operand latches, sign fix-up and HI/LO.

Test Plan:
- WIDTH=32, MULT a=FFFFFFFD(-3) b=00000005 -> done 32 edges after start; hi=FFFFFFFF lo=FFFFFFF1; busy high 32 cycles.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE lo=00000001. Then DIV a=FFFFFFF9(-7) b=2 started in the DONE cycle -> lo=FFFFFFFD hi=FFFFFFFF, exactly 32 edges later.
- DIVU a=00000064 b=0 -> hi=00000064 lo=FFFFFFFF div_by_zero=1. Next DIV 80000000/FFFFFFFF -> lo=80000000 hi=00000000, div_by_zero=0.
- MULT started after hi=1234 lo=5678. Assert flush at iteration 10 -> no done, hi/lo stay 1234/5678, state IDLE next cycle. A second start pulse during RUN is ignored.
- MTHI wdata=AAAA0000 in IDLE -> hi=AAAA0000 next edge. hi_we during RUN -> hi unchanged. lo_we in DONE -> lo=wdata, overriding the result.
- rst asserted mid-RUN -> next edge hi=lo=0, busy=done=0. WIDTH=8 regression: MULT 0x80*0x80 -> hi=0x40 lo=0x00, done after 8 edges.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS core: mul/div opcodes and the mul/div FSM states.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // Opcode bit 1 selects divide, bit 0 selects unsigned.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on unsigned magnitudes.
module mips_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] shreg_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    // Multiply: {acc, shreg} holds the running product, multiplier consumed from shreg[0].
    sum   = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
    // Divide: acc is the partial remainder, dividend bits shift out of shreg's MSB.
    trial = {acc, shreg[WIDTH-1]};
    fits  = (trial >= {1'b0, operand});
    diff  = trial - {1'b0, operand};
    if (div) begin
      acc_next   = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      shreg_next = {shreg[WIDTH-2:0], fits};
    end else begin
      acc_next   = sum[WIDTH:1];
      shreg_next = {sum[0], shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, MTHI/MTLO writes and flush.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  md_state_t          state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               div_reg, neg_q_reg, neg_r_reg, bz_reg;
  logic [WIDTH-1:0]   opnd_reg, acc_reg, sh_reg;
  logic [WIDTH-1:0]   acc_next, sh_next;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               dbz_reg;

  logic               accept, last_iter;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  assign accept    = start && (state_reg != MD_RUN);
  assign last_iter = (state_reg == MD_RUN) && !flush && (cnt_reg == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= MD_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MD_IDLE: if (start) state_next = MD_RUN;
      MD_RUN: begin
        if (flush)                      state_next = MD_IDLE;
        else if (cnt_reg == LAST_CNT)   state_next = MD_DONE;
      end
      MD_DONE: state_next = start ? MD_RUN : MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_reg == MD_RUN);
    done        = (state_reg == MD_DONE);
    div_by_zero = dbz_reg;
    hi          = hi_reg;
    lo          = lo_reg;
  end

  // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
  always_comb begin
    a_neg = md_is_signed(op) && a[WIDTH-1];
    b_neg = md_is_signed(op) && b[WIDTH-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
  end

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div        (div_reg),
    .acc        (acc_reg),
    .shreg      (sh_reg),
    .operand    (opnd_reg),
    .acc_next   (acc_next),
    .shreg_next (sh_next)
  );

  // Sign fix-up works on the final iteration's outputs so results land on the last edge.
  always_comb begin
    prod     = {acc_next, sh_next};
    prod_fix = neg_q_reg ? -prod : prod;
    quo_fix  = bz_reg ? '1 : (neg_q_reg ? -sh_next : sh_next);
    rem_fix  = neg_r_reg ? -acc_next : acc_next;
    res_hi   = div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = div_reg ? quo_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      div_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      bz_reg    <= 1'b0;
      opnd_reg  <= '0;
      acc_reg   <= '0;
      sh_reg    <= '0;
    end else if (accept) begin
      cnt_reg   <= '0;
      div_reg   <= md_is_div(op);
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
      bz_reg    <= (b == '0);
      acc_reg   <= '0;
      opnd_reg  <= md_is_div(op) ? mag_b : mag_a;
      sh_reg    <= md_is_div(op) ? mag_a : mag_b;
    end else if (state_reg == MD_RUN) begin
      cnt_reg   <= cnt_reg + CNT_W'(1);
      acc_reg   <= acc_next;
      sh_reg    <= sh_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg  <= '0;
      lo_reg  <= '0;
      dbz_reg <= 1'b0;
    end else begin
      if (accept) dbz_reg <= 1'b0;
      if (last_iter) begin
        hi_reg  <= res_hi;
        lo_reg  <= res_lo;
        dbz_reg <= div_reg && bz_reg;
      end else if (state_reg != MD_RUN) begin
        if (hi_we) hi_reg <= wdata;
        if (lo_we) lo_reg <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench: vector table for the 32-bit unit plus hand sequences and an 8-bit instance.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  logic        start_8 = 1'b0, flush_8 = 1'b0, hi_we_8 = 1'b0, lo_we_8 = 1'b0;
  logic [1:0]  op_8 = 2'b00;
  logic [7:0]  a_8 = '0, b_8 = '0, wdata_8 = '0;
  logic        busy_8, done_8, dbz_8;
  logic [7:0]  hi_8, lo_8;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_8), .op(op_8), .a(a_8), .b(b_8), .flush(flush_8),
    .hi_we(hi_we_8), .lo_we(lo_we_8), .wdata(wdata_8), .busy(busy_8), .done(done_8),
    .div_by_zero(dbz_8), .hi(hi_8), .lo(lo_8)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[11];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an op at the current point (just after an edge) and wait for done.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_dbz_clear", div_by_zero, 0);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int lat);
    op_8 = o; a_8 = x; b_8 = y; start_8 = 1'b1;
    tick();
    start_8 = 1'b0;
    lat = 0;
    while (!done_8 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, ndone;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[6]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[10] = '{MD_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};

    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;
    tick();

    // Vectors run back-to-back: each start after the first lands in the DONE cycle.
    for (int i = 0; i < 11; i++) begin
      run32(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, div_by_zero, lat);
      check($sformatf("v%0d_latency", i), lat, 32);
      check($sformatf("v%0d_busy_cycles", i), bcnt, 32);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].dbz);
    end
    tick();
    check("done_one_cycle", done, 0);
    tick();

    // MTHI/MTLO from IDLE.
    hi_we = 1'b1; wdata = 32'h00001234;
    tick();
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'h00001234);
    lo_we = 1'b1; wdata = 32'h00005678;
    tick();
    lo_we = 1'b0;
    check("mtlo_idle", lo, 32'h00005678);
    $display("mthi/mtlo idle hi=%h lo=%h", hi, lo);

    // Flush at iteration 10 with a simultaneous start: flush wins.
    op = MD_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    flush = 1'b1; start = 1'b1; op = MD_DIVU; a = 32'd1; b = 32'd1;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_hi", hi, 32'h00001234);
    check("flush_lo", lo, 32'h00005678);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("flush_no_activity", ndone, 0);
    check("flush_hi_kept", hi, 32'h00001234);
    $display("flush hi=%h lo=%h", hi, lo);

    // A start pulse mid-RUN is ignored.
    op = MD_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    repeat (3) begin tick(); lat++; end
    start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
    tick();
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin tick(); lat++; end
    check("ignore_start_latency", lat, 32);
    check("ignore_start_hi", hi, 32'h0);
    check("ignore_start_lo", lo, 32'd15);
    $display("ignored start hi=%h lo=%h lat=%0d", hi, lo, lat);
    tick();
    check("ignore_start_no_rerun", busy, 0);

    // MTHI in RUN ignored; MTLO in DONE overrides the result.
    op = MD_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    repeat (2) begin tick(); lat++; end
    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    lat++;
    hi_we = 1'b0;
    check("mthi_run_ignored", hi, 32'h0);
    while (!done && lat < 40) begin tick(); lat++; end
    check("mul6_lo", lo, 32'd6);
    lo_we = 1'b1; wdata = 32'hCAFEF00D;
    tick();
    lo_we = 1'b0;
    check("mtlo_done_lo", lo, 32'hCAFEF00D);
    check("mtlo_done_hi", hi, 32'h0);
    check("mtlo_done_idle", done, 0);
    $display("mtlo in done hi=%h lo=%h", hi, lo);

    hi_we = 1'b1; wdata = 32'hAAAA0000;
    tick();
    hi_we = 1'b0;
    check("mthi_aaaa", hi, 32'hAAAA0000);

    // Reset mid-RUN.
    op = MD_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    $display("reset mid-run hi=%h lo=%h busy=%0d", hi, lo, busy);

    // WIDTH=8 instance.
    check("w8_rst_hi", hi_8, 8'h00);
    run8(MD_MULT, 8'h80, 8'h80, lat);
    check("w8_mult_latency", lat, 8);
    check("w8_mult_hi", hi_8, 8'h40);
    check("w8_mult_lo", lo_8, 8'h00);
    $display("w8 MULT 80*80 hi=%h lo=%h lat=%0d", hi_8, lo_8, lat);
    run8(MD_DIV, 8'h80, 8'hFF, lat);
    check("w8_div_latency", lat, 8);
    check("w8_div_hi", hi_8, 8'h00);
    check("w8_div_lo", lo_8, 8'h80);
    $display("w8 DIV 80/FF hi=%h lo=%h lat=%0d", hi_8, lo_8, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
